// File: rtl/ac_pkg.sv
// Shared constants, counter-width helper and FSM encoding for the access-control input buffer.
package ac_pkg;

  localparam int AC_PIX_W = 24;
  localparam int AC_SRC_W = 1024;
  localparam int AC_SRC_H = 540;
  localparam int AC_DST_W = 2 * AC_SRC_W;
  localparam int AC_DST_H = 2 * AC_SRC_H;
  localparam int AC_N_PAR = 2;

  // Width able to hold 0..range-1; never narrower than one bit.
  function automatic int cnt_w(input int range);
    return (range > 1) ? $clog2(range) : 1;
  endfunction

  localparam int AC_COL_W  = cnt_w(AC_SRC_W);
  localparam int AC_ROW_W  = cnt_w(AC_SRC_H);
  localparam int AC_LANE_W = cnt_w(AC_N_PAR);
  localparam int AC_HOLD_W = cnt_w(AC_N_PAR + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } inbuf_state_e;

endpackage

// File: rtl/ac_pix_pos_cnt.sv
// Row/column position counter; advances on i_inc and flags the last column and last pixel of a frame.
module ac_pix_pos_cnt
  import ac_pkg::*;
#(
  parameter int COLS  = AC_SRC_W,
  parameter int ROWS  = AC_SRC_H,
  parameter int COL_W = cnt_w(COLS),
  parameter int ROW_W = cnt_w(ROWS)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_inc,
  output logic o_col_wrap,
  output logic o_frame_wrap
);

  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;

  assign o_col_wrap   = (r_col == COL_W'(COLS - 1));
  assign o_frame_wrap = o_col_wrap && (r_row == ROW_W'(ROWS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_inc) begin
      if (o_col_wrap) begin
        r_col <= '0;
        r_row <= o_frame_wrap ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/ac_inbuf.sv
// Serializes N_PARALLEL-pixel words into a one-pixel-per-pop FWFT stream with row/frame markers.
// Build macro AC_INBUF_STALL_CNT_EN adds the saturating starvation counter output stall_cnt.
//
// state | meaning
// IDLE  | holding register empty, waiting for a wide word
// DRAIN | presenting hold_data lane lane_idx to the UPSP core
module ac_inbuf
  import ac_pkg::*;
#(
  parameter int UPSP_RDDATA_WIDTH = AC_PIX_W,
  parameter int SRC_IMG_WIDTH     = AC_SRC_W,
  parameter int SRC_IMG_HEIGHT    = AC_SRC_H,
  parameter int N_PARALLEL        = AC_N_PAR
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    buf_wvalid,
  input  logic [UPSP_RDDATA_WIDTH*N_PARALLEL-1:0] buf_wdata,
  output logic                                    buf_wready,
  input  logic                                    buf_rd,
  output logic [UPSP_RDDATA_WIDTH-1:0]            buf_rdata,
  output logic                                    buf_empty,
  output logic                                    buf_rlast,
  output logic                                    frame_done
`ifdef AC_INBUF_STALL_CNT_EN
  ,
  output logic [31:0]                             stall_cnt
`endif
);

  localparam int COL_W  = cnt_w(SRC_IMG_WIDTH);
  localparam int ROW_W  = cnt_w(SRC_IMG_HEIGHT);
  localparam int LANE_W = cnt_w(N_PARALLEL);
  localparam int HOLD_W = cnt_w(N_PARALLEL + 1);

  inbuf_state_e r_state, w_state_nxt;

  logic [N_PARALLEL-1:0][UPSP_RDDATA_WIDTH-1:0] r_hold_data;
  logic [LANE_W-1:0] r_lane_idx;
  logic [HOLD_W-1:0] r_hold_n;
  logic [HOLD_W-1:0] w_take_n;
  logic [COL_W-1:0]  r_in_col;
  logic [COL_W-1:0]  w_in_col_nxt;
  logic [31:0]       w_rem;
  logic [31:0]       w_col_sum;
  logic              r_frame_done;
  logic              w_pop;
  logic              w_last_lane;
  logic              w_accept;
  logic              w_col_wrap;
  logic              w_frame_wrap;

  // Row-end words carry only the pixels left in the row; the rest of the lanes are dropped.
  always_comb begin
    w_rem        = 32'(SRC_IMG_WIDTH) - 32'(r_in_col);
    w_take_n     = (w_rem < 32'(N_PARALLEL)) ? HOLD_W'(w_rem) : HOLD_W'(N_PARALLEL);
    w_col_sum    = 32'(r_in_col) + 32'(w_take_n);
    w_in_col_nxt = (w_col_sum >= 32'(SRC_IMG_WIDTH)) ? '0 : COL_W'(w_col_sum);
  end

  assign w_last_lane = ((32'(r_lane_idx) + 32'd1) == 32'(r_hold_n));

  // wready in DRAIN depends combinationally on buf_rd so a new word lands as the last lane leaves.
  always_comb begin
    w_state_nxt = r_state;
    buf_wready  = 1'b0;
    buf_empty   = 1'b1;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        buf_wready = 1'b1;
        if (buf_wvalid) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        buf_empty  = 1'b0;
        w_pop      = buf_rd;
        buf_wready = buf_rd && w_last_lane;
        if (buf_rd && w_last_lane && !buf_wvalid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_accept = buf_wvalid && buf_wready;

  always_comb begin
    buf_rdata = '0;
    if (r_state == DRAIN) begin
      for (int k = 0; k < N_PARALLEL; k++) begin
        if (r_lane_idx == LANE_W'(k)) buf_rdata = r_hold_data[k];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_hold_data  <= '0;
      r_lane_idx   <= '0;
      r_hold_n     <= '0;
      r_in_col     <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        for (int k = 0; k < N_PARALLEL; k++) begin
          r_hold_data[k] <= (k < int'(w_take_n)) ?
                            buf_wdata[k*UPSP_RDDATA_WIDTH +: UPSP_RDDATA_WIDTH] : '0;
        end
        r_hold_n   <= w_take_n;
        r_lane_idx <= '0;
        r_in_col   <= w_in_col_nxt;
      end else if (w_pop) begin
        r_lane_idx <= r_lane_idx + LANE_W'(1);
      end
      r_frame_done <= w_pop && w_frame_wrap;
    end
  end

  ac_pix_pos_cnt #(
    .COLS  (SRC_IMG_WIDTH),
    .ROWS  (SRC_IMG_HEIGHT),
    .COL_W (COL_W),
    .ROW_W (ROW_W)
  ) u_out_pos (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_inc        (w_pop),
    .o_col_wrap   (w_col_wrap),
    .o_frame_wrap (w_frame_wrap)
  );

  assign buf_rlast  = !buf_empty && w_col_wrap;
  assign frame_done = r_frame_done;

`ifdef AC_INBUF_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (r_frame_done) begin
      r_stall_cnt <= '0;
    end else if (buf_rd && buf_empty && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_ac_inbuf.sv
// Directed bench for ac_inbuf: a width-4/height-2 instance (dut4) and a width-5/height-2 instance (dut5).
module tb_ac_inbuf;

  localparam int W = 24;
  localparam int N = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic           wvalid4, rd4, wready4, empty4, rlast4, fd4;
  logic [W*N-1:0] wdata4;
  logic [W-1:0]   rdata4;
  logic           wvalid5, rd5, wready5, empty5, rlast5, fd5;
  logic [W*N-1:0] wdata5;
  logic [W-1:0]   rdata5;
`ifdef AC_INBUF_STALL_CNT_EN
  logic [31:0]    stall4, stall5;
`endif

  int   n_checks = 0;
  int   n_fail   = 0;
  int   g_pop    = 0;
  logic exp_fd   = 1'b0;

  ac_inbuf #(.UPSP_RDDATA_WIDTH(W), .SRC_IMG_WIDTH(4), .SRC_IMG_HEIGHT(2), .N_PARALLEL(N)) dut4 (
    .clk(clk), .rst_n(rst_n), .buf_wvalid(wvalid4), .buf_wdata(wdata4), .buf_wready(wready4),
    .buf_rd(rd4), .buf_rdata(rdata4), .buf_empty(empty4), .buf_rlast(rlast4), .frame_done(fd4)
`ifdef AC_INBUF_STALL_CNT_EN
    , .stall_cnt(stall4)
`endif
  );

  ac_inbuf #(.UPSP_RDDATA_WIDTH(W), .SRC_IMG_WIDTH(5), .SRC_IMG_HEIGHT(2), .N_PARALLEL(N)) dut5 (
    .clk(clk), .rst_n(rst_n), .buf_wvalid(wvalid5), .buf_wdata(wdata5), .buf_wready(wready5),
    .buf_rd(rd5), .buf_rdata(rdata5), .buf_empty(empty5), .buf_rlast(rlast5), .frame_done(fd5)
`ifdef AC_INBUF_STALL_CNT_EN
    , .stall_cnt(stall5)
`endif
  );

  function automatic logic [W-1:0] pix(input int k);
    return 24'hC00000 + 24'(k);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    wvalid4 = 1'b0; rd4 = 1'b0; wdata4 = '0;
    wvalid5 = 1'b0; rd5 = 1'b0; wdata5 = '0;
    #12;
    n_checks++; if (empty4 !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty4); end
    n_checks++; if (wready4 !== 1'b1) begin n_fail++; $display("FAIL reset_wready: got %b expected 1", wready4); end
    n_checks++; if (rdata4 !== 24'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 000000", rdata4); end
    n_checks++; if (rlast4 !== 1'b0) begin n_fail++; $display("FAIL reset_rlast: got %b expected 0", rlast4); end
    n_checks++; if (fd4 !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b expected 0", fd4); end
    n_checks++; if (empty5 !== 1'b1) begin n_fail++; $display("FAIL reset_empty5: got %b expected 1", empty5); end
`ifdef AC_INBUF_STALL_CNT_EN
    n_checks++; if (stall4 !== 32'd0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall4); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    wvalid4 = 1'b1; wdata4 = {24'h000002, 24'h000001};
    @(negedge clk);
    n_checks++; if (empty4 !== 1'b1) begin n_fail++; $display("FAIL basic_empty_before: got %b expected 1", empty4); end
    n_checks++; if (wready4 !== 1'b1) begin n_fail++; $display("FAIL basic_wready: got %b expected 1", wready4); end
    @(posedge clk); #1;
    wvalid4 = 1'b0; rd4 = 1'b1;
    @(negedge clk);
    n_checks++; if (empty4 !== 1'b0) begin n_fail++; $display("FAIL basic_empty_fall: got %b expected 0", empty4); end
    n_checks++; if (rdata4 !== 24'h000001) begin n_fail++; $display("FAIL basic_lane0: got %h expected 000001", rdata4); end
    n_checks++; if (rlast4 !== 1'b0) begin n_fail++; $display("FAIL basic_rlast0: got %b expected 0", rlast4); end
    @(posedge clk); #1;
    g_pop++;
    @(negedge clk);
    n_checks++; if (rdata4 !== 24'h000002) begin n_fail++; $display("FAIL basic_lane1: got %h expected 000002", rdata4); end
    n_checks++; if (empty4 !== 1'b0) begin n_fail++; $display("FAIL basic_empty_lane1: got %b expected 0", empty4); end
    @(posedge clk); #1;
    rd4 = 1'b0; g_pop++;
    @(negedge clk);
    n_checks++; if (empty4 !== 1'b1) begin n_fail++; $display("FAIL basic_drained: got %b expected 1", empty4); end
    @(posedge clk); #1;
  endtask

  // Streams n_words full words with wvalid and rd held high; pixel value pix(base+i) in stream order.
  task automatic test_back_to_back(input int n_words, input int base);
    int   pres;
    logic acc;
    logic fd_nxt;
    logic exp_rl;
    wvalid4 = 1'b1; wdata4 = {pix(base + 1), pix(base)}; rd4 = 1'b0;
    @(negedge clk);
    n_checks++; if (wready4 !== 1'b1) begin n_fail++; $display("FAIL b2b_first_ready: got %b expected 1", wready4); end
    @(posedge clk); #1;
    pres = 1;
    wdata4 = {pix(base + 3), pix(base + 2)};
    if (n_words == 1) wvalid4 = 1'b0;
    rd4 = 1'b1;
    for (int k = 0; k < 2 * n_words; k++) begin
      @(negedge clk);
      exp_rl = ((g_pop % 4) == 3);
      n_checks++; if (empty4 !== 1'b0) begin n_fail++; $display("FAIL b2b_no_bubble[%0d]: got empty=%b expected 0", k, empty4); end
      n_checks++; if (rdata4 !== pix(base + k)) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", k, rdata4, pix(base + k)); end
      n_checks++; if (rlast4 !== exp_rl) begin n_fail++; $display("FAIL b2b_rlast[%0d]: got %b expected %b", k, rlast4, exp_rl); end
      n_checks++; if (fd4 !== exp_fd) begin n_fail++; $display("FAIL b2b_frame_done[%0d]: got %b expected %b", k, fd4, exp_fd); end
      acc    = wvalid4 && wready4;
      fd_nxt = ((g_pop % 8) == 7);
      g_pop++;
      @(posedge clk); #1;
      exp_fd = fd_nxt;
      if (acc) begin
        pres++;
        if (pres < n_words) wdata4 = {pix(base + 2 * pres + 1), pix(base + 2 * pres)};
        else wvalid4 = 1'b0;
      end
    end
    rd4 = 1'b0;
    @(negedge clk);
    n_checks++; if (empty4 !== 1'b1) begin n_fail++; $display("FAIL b2b_drained: got %b expected 1", empty4); end
    n_checks++; if (fd4 !== exp_fd) begin n_fail++; $display("FAIL b2b_tail_frame_done: got %b expected %b", fd4, exp_fd); end
    exp_fd = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_frame();
    test_back_to_back(3, 'h20);
    @(negedge clk);
    n_checks++; if (fd4 !== 1'b0) begin n_fail++; $display("FAIL frame_done_one_cycle: got %b expected 0", fd4); end
    n_checks++; if (dut4.u_out_pos.r_row !== 1'd0) begin n_fail++; $display("FAIL frame_row_wrap: got %0d expected 0", dut4.u_out_pos.r_row); end
    wvalid4 = 1'b1; wdata4 = {pix('h31), pix('h30)};
    @(posedge clk); #1;
    wvalid4 = 1'b0; rd4 = 1'b1;
    @(negedge clk);
    n_checks++; if (dut4.u_out_pos.r_col !== 2'd0) begin n_fail++; $display("FAIL frame_next_col: got %0d expected 0", dut4.u_out_pos.r_col); end
    n_checks++; if (rdata4 !== pix('h30)) begin n_fail++; $display("FAIL frame_next_pixel: got %h expected %h", rdata4, pix('h30)); end
    n_checks++; if (rlast4 !== 1'b0) begin n_fail++; $display("FAIL frame_next_rlast: got %b expected 0", rlast4); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (rdata4 !== pix('h31)) begin n_fail++; $display("FAIL frame_next_lane1: got %h expected %h", rdata4, pix('h31)); end
    @(posedge clk); #1;
    rd4 = 1'b0; g_pop += 2;
  endtask

  task automatic test_partial();
    logic [W*N-1:0] words [4];
    logic [W-1:0]   exp_px [7];
    int             pres;
    logic           acc;
    words[0] = {24'h000011, 24'h000010};
    words[1] = {24'h000013, 24'h000012};
    words[2] = {24'hBBBBBB, 24'hAAAAAA};
    words[3] = {24'h000021, 24'h000020};
    exp_px[0] = 24'h000010; exp_px[1] = 24'h000011; exp_px[2] = 24'h000012; exp_px[3] = 24'h000013;
    exp_px[4] = 24'hAAAAAA; exp_px[5] = 24'h000020; exp_px[6] = 24'h000021;
    wvalid5 = 1'b1; wdata5 = words[0]; rd5 = 1'b0;
    @(posedge clk); #1;
    pres = 1; wdata5 = words[1]; rd5 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      n_checks++; if (empty5 !== 1'b0) begin n_fail++; $display("FAIL partial_empty[%0d]: got %b expected 0", k, empty5); end
      n_checks++; if (rdata5 !== exp_px[k]) begin n_fail++; $display("FAIL partial_data[%0d]: got %h expected %h", k, rdata5, exp_px[k]); end
      n_checks++; if (rlast5 !== (k == 4)) begin n_fail++; $display("FAIL partial_rlast[%0d]: got %b expected %b", k, rlast5, (k == 4)); end
      n_checks++; if (fd5 !== 1'b0) begin n_fail++; $display("FAIL partial_frame_done[%0d]: got %b expected 0", k, fd5); end
      acc = wvalid5 && wready5;
      @(posedge clk); #1;
      if (acc) begin
        pres++;
        if (pres < 4) wdata5 = words[pres];
        else wvalid5 = 1'b0;
      end
    end
    rd5 = 1'b0;
    @(negedge clk);
    n_checks++; if (empty5 !== 1'b1) begin n_fail++; $display("FAIL partial_drained: got %b expected 1", empty5); end
`ifdef AC_INBUF_STALL_CNT_EN
    n_checks++; if (stall5 !== 32'd0) begin n_fail++; $display("FAIL partial_stall_cnt: got %0d expected 0", stall5); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    rd4 = 1'b1; wvalid4 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (empty4 !== 1'b1) begin n_fail++; $display("FAIL stall_empty[%0d]: got %b expected 1", i, empty4); end
      @(posedge clk); #1;
    end
    rd4 = 1'b0; wvalid4 = 1'b1; wdata4 = {pix('h41), pix('h40)};
    @(posedge clk); #1;
    wvalid4 = 1'b0;
    @(negedge clk);
    n_checks++; if (empty4 !== 1'b0) begin n_fail++; $display("FAIL stall_word_arrives: got %b expected 0", empty4); end
    n_checks++; if (rdata4 !== pix('h40)) begin n_fail++; $display("FAIL stall_first_pixel: got %h expected %h", rdata4, pix('h40)); end
    n_checks++; if (dut4.u_out_pos.r_col !== 2'd2) begin n_fail++; $display("FAIL stall_no_spurious_pop: got col %0d expected 2", dut4.u_out_pos.r_col); end
`ifdef AC_INBUF_STALL_CNT_EN
    n_checks++; if (stall4 !== 32'd5) begin n_fail++; $display("FAIL stall_cnt: got %0d expected 5", stall4); end
`endif
    rd4 = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (rdata4 !== pix('h41)) begin n_fail++; $display("FAIL stall_second_pixel: got %h expected %h", rdata4, pix('h41)); end
    n_checks++; if (rlast4 !== 1'b1) begin n_fail++; $display("FAIL stall_rlast: got %b expected 1", rlast4); end
    @(posedge clk); #1;
    rd4 = 1'b0; g_pop += 2;
  endtask

  task automatic test_reset_mid();
    wvalid4 = 1'b1; wdata4 = {pix('h51), pix('h50)};
    @(posedge clk); #1;
    wvalid4 = 1'b0; rd4 = 1'b1;
    @(posedge clk); #1;
    rd4 = 1'b0;
    @(negedge clk);
    n_checks++; if (rdata4 !== pix('h51)) begin n_fail++; $display("FAIL rstmid_pending_lane1: got %h expected %h", rdata4, pix('h51)); end
    #1 rst_n = 1'b0;
    #1;
    n_checks++; if (empty4 !== 1'b1) begin n_fail++; $display("FAIL rstmid_empty: got %b expected 1", empty4); end
    n_checks++; if (wready4 !== 1'b1) begin n_fail++; $display("FAIL rstmid_wready: got %b expected 1", wready4); end
    n_checks++; if (rdata4 !== 24'h0) begin n_fail++; $display("FAIL rstmid_rdata: got %h expected 000000", rdata4); end
    n_checks++; if (dut4.u_out_pos.r_col !== 2'd0) begin n_fail++; $display("FAIL rstmid_col: got %0d expected 0", dut4.u_out_pos.r_col); end
    @(posedge clk); #1;
    rst_n = 1'b1; g_pop = 0; exp_fd = 1'b0;
    wvalid4 = 1'b1; wdata4 = {pix('h61), pix('h60)};
    @(posedge clk); #1;
    wvalid4 = 1'b0; rd4 = 1'b1;
    @(negedge clk);
    n_checks++; if (empty4 !== 1'b0) begin n_fail++; $display("FAIL rstmid_new_empty: got %b expected 0", empty4); end
    n_checks++; if (rdata4 !== pix('h60)) begin n_fail++; $display("FAIL rstmid_new_lane0: got %h expected %h", rdata4, pix('h60)); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (rdata4 !== pix('h61)) begin n_fail++; $display("FAIL rstmid_new_lane1: got %h expected %h", rdata4, pix('h61)); end
    @(posedge clk); #1;
    rd4 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back(4, 'h10);
    test_frame();
    test_partial();
    test_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit expected normal completion");
    $fatal(1);
  end

endmodule

// File: doc/ac_inbuf.md
Name: ac_inbuf

Overview:
PS-to-IP input buffer for the access control module. Accepts wide AXI-Stream-derived words, each carrying N_PARALLEL source pixels, and serializes them into a one-pixel-per-read stream for the UPSP core. Row-end words may be partially filled. Tracks row/column position, flags the last pixel of each row, and pulses at frame end.

Parameters:
- UPSP_RDDATA_WIDTH, 24, bits per pixel.
- SRC_IMG_WIDTH, 1024, source pixels per row; need not be a multiple of N_PARALLEL.
- SRC_IMG_HEIGHT, 540, source rows per frame.
- N_PARALLEL, 2, pixels per wide input word; must be >= 1.

Ports:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- buf_wvalid  in  1  wide word valid.
- buf_wdata  in  UPSP_RDDATA_WIDTH*N_PARALLEL  pixel lanes; lane k at [k*W +: W]; lane 0 is first in stream order.
- buf_wready  out  1  word accepted when buf_wvalid & buf_wready.
- buf_rd  in  1  UPSP pops one pixel.
- buf_rdata  out  UPSP_RDDATA_WIDTH  current pixel, first-word-fall-through.
- buf_empty  out  1  no pixel available.
- buf_rlast  out  1  buf_rdata is the last pixel of a row.
- frame_done  out  1  one-cycle pulse after the final frame pixel is popped.

Behaviour:
- Clock/reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: buf_empty=1, buf_wready=1, buf_rdata=0, buf_rlast=0, frame_done=0, all counters 0, FSM=IDLE.
- Storage: one wide holding register hold_data, lane index lane_idx, and valid-lane count hold_n, in the range 1..N_PARALLEL.
- Input-side column counter in_col (0..SRC_IMG_WIDTH-1), advanced on each accept:
  - hold_n = min(N_PARALLEL, SRC_IMG_WIDTH - in_col).
  - in_col += hold_n, and wraps to 0 when it reaches SRC_IMG_WIDTH.
  - Lanes at or above hold_n are discarded.
- FSM IDLE:
  - buf_empty=1, buf_wready=1.
  - On accept: latch word, lane_idx=0, go to DRAIN.
- FSM DRAIN:
  - buf_empty=0, buf_rdata = hold_data lane lane_idx.
  - On buf_rd: lane_idx++.
  - buf_wready = (buf_rd & lane_idx==hold_n-1). This is a combinational path from buf_rd, giving full throughput with no bubble.
  - If the last lane is popped and a new word is accepted in the same cycle: reload and stay in DRAIN.
  - If the last lane is popped with no new word: go to IDLE.
- Latency: word accepted at cycle t, then buf_empty=0 with lane 0 on buf_rdata at t+1.
- buf_rd while buf_empty=1 is ignored; no counter moves.
- Output-side counters out_col (0..SRC_IMG_WIDTH-1) and out_row (0..SRC_IMG_HEIGHT-1) advance on every effective pop.
  - buf_rlast = ~buf_empty & (out_col == SRC_IMG_WIDTH-1).
- Frame end: a pop at out_col=SRC_IMG_WIDTH-1, out_row=SRC_IMG_HEIGHT-1 does three things:
  - registers frame_done=1 for exactly the next cycle;
  - wraps out_col and out_row to 0;
  - lets the next frame stream immediately, with no stall.
- Counter widths: $clog2 of the range each holds.
- Reset mid-word discards the held word and all position state.

Optional Feature:
Macro AC_INBUF_STALL_CNT_EN.
- Defined:
  - adds output stall_cnt, 32 bits, reset 0;
  - increments each cycle where buf_rd=1 and buf_empty=1 (UPSP starved);
  - saturates at 32'hFFFF_FFFF;
  - clears on frame_done.
- Undefined: the port and its logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ac_pkg holds:
  - the pixel width constant;
  - source and destination image dimensions;
  - N_PARALLEL;
  - derived $clog2 counter widths;
  - the FSM state encoding (IDLE, DRAIN).
- One natural sub-module: ac_pix_pos_cnt, a row/column wrap counter with inc and wrap outputs. It is instantiated for the output side.

Test Plan:
- Reset, then W=24, N=2, width=4, height=2:
  - push 0x000002_000001 → pop returns 0x000001, then 0x000002;
  - buf_empty falls one cycle after accept.
- Width=5, N=2: push three words per row, the last being 0xBBBBBB_AAAAAA → only 0xAAAAAA is delivered, with buf_rlast=1; 0xBBBBBB is never seen.
- Continuous buf_wvalid=1 with buf_rd=1 every cycle → one pixel per cycle and no bubbles across word boundaries; 8 pixels arrive in 8 consecutive cycles.
- Width=4, height=2, full frame popped:
  - frame_done high for exactly 1 cycle after pixel 8;
  - next frame's pixel 1 has out_col=0.
- buf_rd held high while empty for 5 cycles, then one word arrives:
  - no spurious pops; first pixel correct;
  - with the macro defined, stall_cnt=5.
- Assert rst_n low while lane 1 is pending → buf_empty=1 and buf_wready=1 immediately; after release the next word is delivered from lane 0.
